// File: rtl/kda_pkg.sv
// Shared widths, frame layout and host FSM states for the kda 64-bit link.
package kda_pkg;

    localparam int KDA_WORD_W = 64;
    localparam int KDA_PASS_W = 512;
    localparam int KDA_SALT_W = 512;
    localparam int KDA_HASH_W = 1024;

    localparam int KDA_REQ_BEATS       = 17;
    localparam int KDA_BEATS_PER_CHUNK = 4;

    // Header beat layout: {chunks[1:0], salt_len[5:0], iters[31:0], 24'b0}
    localparam int KDA_HDR_CHUNKS_LSB   = 62;
    localparam int KDA_HDR_SALT_LEN_LSB = 56;
    localparam int KDA_HDR_ITERS_LSB    = 24;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV,
        RESP
    } kda_host_state_e;

endpackage

// File: rtl/kda_host_tx.sv
// Request serialiser: latches the 17-beat frame and walks it out over ready/valid.
module kda_host_tx
    import kda_pkg::*;
#(
    parameter int WORD_W = KDA_WORD_W,
    parameter int PASS_W = KDA_PASS_W,
    parameter int SALT_W = KDA_SALT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [1:0]        chunks_i,
    input  logic [5:0]        salt_len_i,
    input  logic [31:0]       iters_i,
    input  logic [PASS_W-1:0] pass_i,
    input  logic [SALT_W-1:0] salt_i,
    input  logic              link_ready_i,
    output logic [WORD_W-1:0] link_data_o,
    output logic              link_v_o,
    output logic              done_o
);

    localparam int PASS_BEATS = PASS_W / WORD_W;
    localparam int SALT_BEATS = SALT_W / WORD_W;
    localparam int BEATS      = 1 + PASS_BEATS + SALT_BEATS;
    localparam int CNT_W      = $clog2(BEATS);

    logic [WORD_W-1:0] frame_in [BEATS];
    logic [WORD_W-1:0] frame_q  [BEATS];
    logic [WORD_W-1:0] frame_d  [BEATS];
    logic [WORD_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              accept;
    logic              last;

    always_comb begin
        frame_in[0] = '0;
        frame_in[0][KDA_HDR_CHUNKS_LSB   +: 2]  = chunks_i;
        frame_in[0][KDA_HDR_SALT_LEN_LSB +: 6]  = salt_len_i;
        frame_in[0][KDA_HDR_ITERS_LSB    +: 32] = iters_i;
        for (int i = 0; i < PASS_BEATS; i++) begin
            frame_in[1+i] = pass_i[PASS_W-1-WORD_W*i -: WORD_W];
        end
        for (int i = 0; i < SALT_BEATS; i++) begin
            frame_in[1+PASS_BEATS+i] = salt_i[SALT_W-1-WORD_W*i -: WORD_W];
        end
    end

    assign accept = active_q & link_ready_i;
    assign last   = (cnt_q == CNT_W'(BEATS - 1));
    assign done_o = accept & last;

    // The output word is registered so it only moves after the current beat is taken.
    always_comb begin
        frame_d  = frame_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            frame_d  = frame_in;
            data_d   = frame_in[0];
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (accept) begin
            if (last) begin
                data_d   = '0;
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                data_d = frame_q[cnt_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < BEATS; i++) begin
                frame_q[i] <= '0;
            end
            data_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign link_data_o = data_q;
    assign link_v_o    = active_q;

endmodule

// File: rtl/kda_host_link.sv
// Host side of the kda link: serialises one request, assembles the hash response.
// Optional KDA_HOST_FULL_RESP_EN: always consume 16 result beats, writing only the requested chunks.
module kda_host_link
    import kda_pkg::*;
#(
    parameter int WORD_W = KDA_WORD_W,
    parameter int PASS_W = KDA_PASS_W,
    parameter int SALT_W = KDA_SALT_W,
    parameter int HASH_W = KDA_HASH_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_v_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_chunks_i,
    input  logic [5:0]        req_salt_len_i,
    input  logic [31:0]       req_iters_i,
    input  logic [PASS_W-1:0] req_pass_i,
    input  logic [SALT_W-1:0] req_salt_i,
    output logic [WORD_W-1:0] link_data_o,
    output logic              link_v_o,
    input  logic              link_ready_i,
    input  logic [WORD_W-1:0] link_data_i,
    input  logic              link_v_i,
    output logic              link_yumi_o,
    output logic [HASH_W-1:0] resp_hash_o,
    output logic [1:0]        resp_chunks_o,
    output logic              resp_v_o,
    input  logic              resp_yumi_i
);

    localparam int HASH_BEATS = HASH_W / WORD_W;
    localparam int RCV_W      = $clog2(HASH_BEATS);

    kda_host_state_e   state_q, state_d;
    logic [HASH_W-1:0] hash_q, hash_d;
    logic [1:0]        chunks_q, chunks_d;
    logic [RCV_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [RCV_W-1:0]  req_last_idx;
    logic              rcv_last;
    logic              rcv_write;
    logic              load;
    logic              tx_done;

    assign req_last_idx = RCV_W'((int'(chunks_q) + 1) * KDA_BEATS_PER_CHUNK - 1);

`ifdef KDA_HOST_FULL_RESP_EN
    assign rcv_last  = (rcv_cnt_q == RCV_W'(HASH_BEATS - 1));
    assign rcv_write = (rcv_cnt_q <= req_last_idx);
`else
    assign rcv_last  = (rcv_cnt_q == req_last_idx);
    assign rcv_write = 1'b1;
`endif

    assign load = (state_q == IDLE) & req_v_i;

    kda_host_tx #(
        .WORD_W (WORD_W),
        .PASS_W (PASS_W),
        .SALT_W (SALT_W)
    ) u_tx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (load),
        .chunks_i     (req_chunks_i),
        .salt_len_i   (req_salt_len_i),
        .iters_i      (req_iters_i),
        .pass_i       (req_pass_i),
        .salt_i       (req_salt_i),
        .link_ready_i (link_ready_i),
        .link_data_o  (link_data_o),
        .link_v_o     (link_v_o),
        .done_o       (tx_done)
    );

    always_comb begin
        state_d     = state_q;
        hash_d      = hash_q;
        chunks_d    = chunks_q;
        rcv_cnt_d   = rcv_cnt_q;
        req_ready_o = 1'b0;
        link_yumi_o = 1'b0;
        resp_v_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_v_i) begin
                    state_d   = SEND;
                    chunks_d  = req_chunks_i;
                    hash_d    = '0;
                    rcv_cnt_d = '0;
                end
            end
            SEND: begin
                if (tx_done) begin
                    state_d   = RECV;
                    rcv_cnt_d = '0;
                end
            end
            RECV: begin
                link_yumi_o = link_v_i;
                if (link_v_i) begin
                    // Beat k lands at the MSB end first: hash[HASH_W-1-WORD_W*k -: WORD_W].
                    for (int k = 0; k < HASH_BEATS; k++) begin
                        if (rcv_write && rcv_cnt_q == RCV_W'(k)) begin
                            hash_d[HASH_W-1-WORD_W*k -: WORD_W] = link_data_i;
                        end
                    end
                    if (rcv_last) begin
                        state_d = RESP;
                    end else begin
                        rcv_cnt_d = rcv_cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            hash_q    <= '0;
            chunks_q  <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hash_q    <= hash_d;
            chunks_q  <= chunks_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

    assign resp_hash_o   = hash_q;
    assign resp_chunks_o = chunks_q;

endmodule

// File: doc/kda_host_link.md
Name: kda_host_link

Overview:
- Host-side counterpart of the kda 64-bit link.
- Takes one parallel key-derivation request and serialises it into 17 ready/valid beats toward kda.
- Collects kda's 64-bit result beats (v/yumi) into a 1024-bit hash and presents it as one parallel response.
- Used by the SoC wrapper and as the bench driver for kda.

Parameters:
- WORD_W, 64, link beat width.
- PASS_W, 512, password field width; multiple of WORD_W.
- SALT_W, 512, salt field width; multiple of WORD_W.
- HASH_W, 1024, maximum derived-key width (4 chunks x 256).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_chunks_i  in  2  number of 256-bit chunks minus one.
- req_salt_len_i  in  6  salt length in bytes.
- req_iters_i  in  32  iteration count.
- req_pass_i  in  PASS_W  password.
- req_salt_i  in  SALT_W  salt.
- link_data_o  out  WORD_W  beat to kda data_i.
- link_v_o  out  1  beat valid.
- link_ready_i  in  1  kda ready_o.
- link_data_i  in  WORD_W  beat from kda data_o.
- link_v_i  in  1  kda v_o.
- link_yumi_o  out  1  beat consumed (to kda yumi_i).
- resp_hash_o  out  HASH_W  assembled hash; chunk0 in [1023:768].
- resp_chunks_o  out  2  chunks field of the completed request.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed; legal only while resp_v_o=1.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous, active-high.
- Reset values: state=IDLE, all counters and registers zero. Outputs: req_ready_o=1 after reset, link_v_o=0, link_yumi_o=0, resp_v_o=0, link_data_o=0, resp_hash_o=0, resp_chunks_o=0.
- Request frame, 17 beats, sent in order:
  - beat0 = {chunks[1:0], salt_len[5:0], iters[31:0], 24'b0}.
  - beats1-8 = pass, most-significant 64 bits first.
  - beats9-16 = salt, most-significant 64 bits first.
- State IDLE:
  - req_ready_o=1.
  - On req_v_i: latch all request fields, clear hash register, beat_cnt=0, go to SEND.
- State SEND:
  - link_v_o=1; link_data_o=frame[beat_cnt], registered.
  - On link_ready_i: beat_cnt++. When beat 16 is accepted, go to RECV with rcv_cnt=0.
  - First beat appears the cycle after request acceptance.
  - link_v_o never drops and link_data_o never changes until the beat is accepted.
- State RECV:
  - link_yumi_o = link_v_i, combinational, one beat per cycle.
  - Beat k is written to hash[HASH_W-1-64k -: 64].
  - Expected beat count N = 4*(chunks+1), i.e. 4/8/12/16. When beat N-1 is consumed, go to RESP.
  - Hash bits beyond N beats stay zero.
- State RESP:
  - resp_v_o=1; resp_hash_o and resp_chunks_o hold stable.
  - On resp_yumi_i, go to IDLE; req_ready_o=1 the next cycle.
- Link handshake rules:
  - link_yumi_o is 0 outside RECV, so result beats arriving early are stalled, never dropped.
  - req_ready_o is 0 outside IDLE.
- Reset mid-operation: immediate return to IDLE with all registers cleared; partial frames are abandoned and the kda side must be reset together.
- Exactly one request is in flight at a time; no pipelining.

Optional Feature:
- Macro KDA_HOST_FULL_RESP_EN.
- Defined: RECV always consumes 16 beats regardless of chunks. Beats with index >= 4*(chunks+1) are consumed but not written, so those hash bits stay zero. This matches a kda that always streams the full 1024-bit hash.
- Undefined: N = 4*(chunks+1) as above.

Decomposition:
- Package kda_pkg holds:
  - KDA_WORD_W, KDA_PASS_W, KDA_SALT_W, KDA_HASH_W.
  - KDA_REQ_BEATS=17 and KDA_BEATS_PER_CHUNK=4.
  - Header field offsets.
  - Host state enum kda_host_state_e {IDLE, SEND, RECV, RESP}.
- One sub-module: kda_host_tx. It holds the latched frame register, the beat counter and the link_data_o mux, and raises a done pulse to the top FSM.
- RECV assembly and the FSM stay in kda_host_link.

Test Plan:
- chunks=0, iters=1, pass=512'h70617373..., salt=512'h73616c74..., link_ready_i=1 always:
  - beat0 = {2'd0, salt_len, 32'd1, 24'b0};
  - beats 1-16 match pass then salt MSW-first;
  - RECV consumes exactly 4 beats; resp_hash_o[767:0]=0.
- Same request with link_ready_i toggling 1/0 every cycle: each beat held stable while unaccepted; 17 beats total; no duplicates.
- chunks=3, kda returns beats 64'h0..64'hF: resp_hash_o = {64'h0,...,64'hF}, MSB-first; resp_chunks_o=3.
- link_v_i asserted during SEND: link_yumi_o=0 until RECV; first consumed beat lands in [1023:960].
- resp_yumi_i held 0 for 10 cycles: resp_v_o and resp_hash_o stable. A new req_v_i during that time is not accepted.
- reset_i pulsed at SEND beat 5: next cycle req_ready_o=1 and link_v_o=0. A fresh request restarts at beat0.
- With KDA_HOST_FULL_RESP_EN defined, chunks=1: 16 beats consumed; resp_hash_o[511:0]=0.
